irq_csr_unit: RTL and testbench
===============================

Name: irq_csr_unit

Overview:
- Interrupt and CSR unit for the single-cycle SimpleRISC core; sits directly upstream of the flag extraction stage.
- Latches external interrupt requests, masks and prioritises them, and redirects the PC on interrupt entry.
- Saves the live GT/EQ flags and return PC on entry; drives saved flags (flags_out_reg) and csr_flag back to the flag stage for iret and rdcsr.

Parameters:
- NUM_IRQ, 4, number of interrupt lines (1..8).
- PC_W, 32, PC width.
- VEC_BASE, 32'h0000_0100, address of vector 0.
- VEC_STRIDE, 16, byte distance between consecutive vectors (power of 2).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- irq_in  in  NUM_IRQ  level interrupt lines, already synchronous to clk.
- gt_flag  in  1  current GT flag from flag stage.
- eq_flag  in  1  current EQ flag from flag stage.
- pc_next  in  PC_W  address of next sequential/branch-resolved instruction.
- instr_valid  in  1  an instruction retires this cycle.
- is_iret  in  1  retiring instruction is iret.
- is_rdcsr  in  1  retiring instruction is rdcsr.
- is_wrcsr  in  1  retiring instruction is wrcsr.
- csr_addr  in  2  CSR select.
- csr_wdata  in  32  CSR write data.
- csr_rdata  out  32  CSR read data.
- csr_flag  out  1  (csr_rdata != 0) when is_rdcsr, else 0.
- flags_out_reg  out  2  saved {GT,EQ}.
- take_irq  out  1  one-cycle PC redirect pulse.
- irq_vector  out  PC_W  redirect target, valid while take_irq.
- epc  out  PC_W  saved return PC, used as the iret target.
- in_isr  out  1  handler active.

Behaviour:
- Reset (synchronous, any state, including mid-ISR):
  - state=RUN; pending=0, ie=0, epc=0, cause=0, saved flags=0, irq_prev=0.
  - All outputs 0.
- Edge detect: irq_prev<=irq_in each cycle; rise = irq_in & ~irq_prev sets pending bits.
- Pending clear sources:
  - wrcsr to addr 1 clears the bits written as 1 (write-1-to-clear).
  - Taking an interrupt clears its own pending bit.
  - A rise wins over any clear in the same cycle.
- CSR map, read combinational:
  - addr 0: IE = {mask[NUM_IRQ-1:0], gie}, read/write, upper bits read 0.
  - addr 1: pending, W1C.
  - addr 2: epc, read-only.
  - addr 3: cause (index of the interrupt taken), read-only.
  - Writes to addr 2 and 3 are ignored.
  - CSR writes are qualified by instr_valid & is_wrcsr and take effect the next cycle.
- Priority: the lowest set index of (pending & mask) wins.
- FSM RUN:
  - If gie & |(pending&mask) & instr_valid: epc<=pc_next, saved flags<={gt_flag,eq_flag}, cause<=winner, clear pending[winner]; next state TAKE.
  - is_iret in RUN is ignored; state and registers are unchanged.
- FSM TAKE (exactly 1 cycle):
  - take_irq=1; irq_vector = VEC_BASE + cause*VEC_STRIDE.
  - Next state ISR. No new entry is evaluated.
- FSM ISR:
  - in_isr=1; no nesting, pending bits still accumulate.
  - On instr_valid & is_iret: next state RUN; flags_out_reg keeps the saved value through the iret cycle.
  - A new entry can be taken no earlier than the cycle after return to RUN.
- Outputs outside TAKE: irq_vector=0, take_irq=0.
- flags_out_reg is a register output, always driven from the saved flags.
- Latency:
  - irq_in rises in cycle N; pending is visible in N+1.
  - If entry conditions hold in N+1, take_irq is high in N+2.
- Simultaneous wrcsr clearing gie and an entry condition in the same cycle: entry is taken, because the write lands one cycle later.

Test Plan:
- Reset, then wrcsr addr0=0x3 (gie=1, mask[0]=1); pulse irq_in[0]; pc_next=0x40, gt=1, eq=0, instr_valid=1 -> take_irq high exactly 2 cycles after the rise, irq_vector=0x100, epc=0x40, flags_out_reg=2'b10, cause=0, in_isr=1, pending=0.
- irq_in[3] and irq_in[1] rise together, mask=0xF, gie=1 -> irq_vector=0x110, cause=1; after iret the next entry gives irq_vector=0x130, cause=3.
- In ISR, raise irq_in[2] -> pending[2]=1, no take_irq until iret retires; take_irq fires the cycle after return to RUN.
- gie=0 with a pending bit; rdcsr addr1 -> csr_rdata=0x4, csr_flag=1; wrcsr addr1=0x4 -> pending=0; rdcsr addr1 -> csr_flag=0.
- Same cycle: irq_in[0] rises and W1C of bit 0 -> pending[0]=1 (set wins). iret while in RUN -> no state change.
- Assert rst while in ISR -> next cycle state RUN, in_isr=0, epc=0, flags_out_reg=0, ie=0.

Source files
------------

// File: rtl/irq_csr_unit.sv
// Interrupt/CSR unit for the SimpleRISC core: latches edges, masks and prioritises them,
// redirects the PC on entry and saves the live flags and return PC for iret and rdcsr.

module irq_line (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clr,
    output logic pending
);
    logic irq_prev;

    // A rising edge outranks any clear landing in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev <= 1'b0;
            pending  <= 1'b0;
        end else begin
            irq_prev <= irq;
            pending  <= (pending & ~clr) | (irq & ~irq_prev);
        end
    end
endmodule

module irq_csr_unit #(
    parameter int                NUM_IRQ    = 4,
    parameter int                PC_W       = 32,
    parameter logic [PC_W-1:0]   VEC_BASE   = PC_W'(32'h0000_0100),
    parameter int                VEC_STRIDE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               gt_flag,
    input  logic               eq_flag,
    input  logic [PC_W-1:0]    pc_next,
    input  logic               instr_valid,
    input  logic               is_iret,
    input  logic               is_rdcsr,
    input  logic               is_wrcsr,
    input  logic [1:0]         csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_flag,
    output logic [1:0]         flags_out_reg,
    output logic               take_irq,
    output logic [PC_W-1:0]    irq_vector,
    output logic [PC_W-1:0]    epc,
    output logic               in_isr
);
    localparam int CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int SH = $clog2(VEC_STRIDE);

    typedef enum logic [1:0] {RUN, TAKE, ISR} state_t;

    state_t             state, state_nx;
    logic [NUM_IRQ-1:0] pending, mask, active, take_clr, clr;
    logic               gie, wr_en, entry;
    logic [CW-1:0]      cause, winner;
    logic [1:0]         saved_flags;
    logic               unused_wdata;

    assign unused_wdata = ^csr_wdata[31:NUM_IRQ+1];

    assign wr_en  = instr_valid & is_wrcsr;
    assign active = pending & mask;
    assign entry  = (state == RUN) & gie & (|active) & instr_valid;

    // Lowest index wins: scan downward so the last hit is the smallest
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (active[i]) winner = CW'(i);
    end

    always_comb begin
        take_clr = '0;
        if (entry) take_clr[winner] = 1'b1;
    end

    assign clr = take_clr | ((wr_en && csr_addr == 2'd1) ? csr_wdata[NUM_IRQ-1:0] : '0);

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_line u_line (
            .clk     (clk),
            .rst     (rst),
            .irq     (irq_in[g]),
            .clr     (clr[g]),
            .pending (pending[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (entry) state_nx = TAKE;
            TAKE:    state_nx = ISR;
            ISR:     if (instr_valid && is_iret) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // Entry samples the current gie, so a same-cycle write disabling it lands too late
    always_ff @(posedge clk) begin
        if (rst) begin
            gie         <= 1'b0;
            mask        <= '0;
            epc         <= '0;
            cause       <= '0;
            saved_flags <= 2'b00;
        end else begin
            if (wr_en && csr_addr == 2'd0) {mask, gie} <= csr_wdata[NUM_IRQ:0];
            if (entry) begin
                epc         <= pc_next;
                saved_flags <= {gt_flag, eq_flag};
                cause       <= winner;
            end
        end
    end

    assign take_irq      = (state == TAKE);
    assign in_isr        = (state == ISR);
    assign flags_out_reg = saved_flags;
    assign irq_vector    = take_irq ? VEC_BASE + (PC_W'(cause) << SH) : '0;

    always_comb begin
        case (csr_addr)
            2'd0:    csr_rdata = 32'({mask, gie});
            2'd1:    csr_rdata = 32'(pending);
            2'd2:    csr_rdata = 32'(epc);
            default: csr_rdata = 32'(cause);
        endcase
    end

    assign csr_flag = is_rdcsr & (csr_rdata != 32'd0);
endmodule

// File: tb/tb_irq_csr_unit.sv
// Bench for irq_csr_unit: directed vector table, hand-written corner sequences and a
// randomized run against a behavioural reference model.

module tb_irq_csr_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_in;
    logic        gt_flag, eq_flag;
    logic [31:0] pc_next;
    logic        instr_valid, is_iret, is_rdcsr, is_wrcsr;
    logic [1:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_flag;
    logic [1:0]  flags_out_reg;
    logic        take_irq;
    logic [31:0] irq_vector;
    logic [31:0] epc;
    logic        in_isr;

    int total = 0;
    int bad   = 0;

    irq_csr_unit dut (
        .clk           (clk),
        .rst           (rst),
        .irq_in        (irq_in),
        .gt_flag       (gt_flag),
        .eq_flag       (eq_flag),
        .pc_next       (pc_next),
        .instr_valid   (instr_valid),
        .is_iret       (is_iret),
        .is_rdcsr      (is_rdcsr),
        .is_wrcsr      (is_wrcsr),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .csr_flag      (csr_flag),
        .flags_out_reg (flags_out_reg),
        .take_irq      (take_irq),
        .irq_vector    (irq_vector),
        .epc           (epc),
        .in_isr        (in_isr)
    );

    always #5 clk = ~clk;

    typedef logic [100:0] ovec_t;

    typedef struct {
        logic        rst;
        logic [3:0]  irq;
        logic        iv, iret, rd, wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        gt, eq;
        logic [31:0] pc;
        logic        take;
        logic [31:0] vec, epc;
        logic [1:0]  flags;
        logic        isr;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(int rs, int irq, int iv, int ir, int rd, int wr, int ad, int wd,
                                int gt, int eq, int pc, int tk, int vc, int ep, int fl, int isr,
                                int rdt);
        vec_t v;
        v.rst = 1'(rs);   v.irq = 4'(irq);  v.iv = 1'(iv);    v.iret = 1'(ir);
        v.rd = 1'(rd);    v.wr = 1'(wr);    v.addr = 2'(ad);  v.wdata = 32'(wd);
        v.gt = 1'(gt);    v.eq = 1'(eq);    v.pc = 32'(pc);   v.take = 1'(tk);
        v.vec = 32'(vc);  v.epc = 32'(ep);  v.flags = 2'(fl); v.isr = 1'(isr);
        v.rdata = 32'(rdt);
        return v;
    endfunction

    function automatic ovec_t pack(logic tk, logic [31:0] vc, logic [31:0] ep, logic [1:0] fl,
                                   logic isr, logic [31:0] rdt, logic flg);
        return {tk, vc, ep, fl, isr, rdt, flg};
    endfunction

    function automatic ovec_t dut_out();
        return pack(take_irq, irq_vector, epc, flags_out_reg, in_isr, csr_rdata, csr_flag);
    endfunction

    task automatic chk(input string nm, input ovec_t act, input ovec_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int irq, input int iv, input int ir, input int rd, input int wr,
                       input int ad, input int wd);
        rst = 1'b0; irq_in = 4'(irq); instr_valid = 1'(iv); is_iret = 1'(ir);
        is_rdcsr = 1'(rd); is_wrcsr = 1'(wr); csr_addr = 2'(ad); csr_wdata = 32'(wd);
    endtask

    // Reference model: architectural state tracked from the rules, not the RTL
    int          m_mode;   // 0 running, 1 redirect cycle, 2 in handler
    logic [3:0]  m_pend, m_prev, m_mask;
    logic        m_gie;
    logic [31:0] m_epc;
    int          m_cause;
    logic [1:0]  m_flags;

    function automatic ovec_t model_out();
        logic [31:0] rdt;
        logic        tk;
        case (csr_addr)
            2'd0:    rdt = {27'd0, m_mask, m_gie};
            2'd1:    rdt = {28'd0, m_pend};
            2'd2:    rdt = m_epc;
            default: rdt = 32'(m_cause);
        endcase
        tk = (m_mode == 1);
        return pack(tk, tk ? 32'h100 + 32'(m_cause) * 32'd16 : 32'd0, m_epc, m_flags,
                    m_mode == 2, rdt, is_rdcsr && rdt != 0);
    endfunction

    task automatic model_step();
        logic [3:0] rise, clr;
        int nmode;
        if (rst) begin
            m_mode = 0; m_pend = 0; m_prev = 0; m_mask = 0; m_gie = 0;
            m_epc = 0; m_cause = 0; m_flags = 0;
            return;
        end
        rise  = irq_in & ~m_prev;
        clr   = 0;
        nmode = m_mode;
        if (m_mode == 0 && m_gie && (m_pend & m_mask) != 0 && instr_valid) begin
            for (int i = 3; i >= 0; i--)
                if (m_pend[i] && m_mask[i]) m_cause = i;
            m_epc   = pc_next;
            m_flags = {gt_flag, eq_flag};
            clr[m_cause] = 1'b1;
            nmode   = 1;
        end else if (m_mode == 1) begin
            nmode = 2;
        end else if (m_mode == 2 && instr_valid && is_iret) begin
            nmode = 0;
        end
        if (instr_valid && is_wrcsr && csr_addr == 2'd1) clr = clr | csr_wdata[3:0];
        if (instr_valid && is_wrcsr && csr_addr == 2'd0) {m_mask, m_gie} = csr_wdata[4:0];
        m_pend = (m_pend & ~clr) | rise;
        m_prev = irq_in;
        m_mode = nmode;
    endtask

    initial begin
        rst = 1'b1; irq_in = 0; gt_flag = 0; eq_flag = 0; pc_next = 0;
        instr_valid = 0; is_iret = 0; is_rdcsr = 0; is_wrcsr = 0; csr_addr = 0; csr_wdata = 0;

        //          rs irq iv ir rd wr ad wd    gt eq pc      tk vc     ep     fl isr rdata
        tbl[0]  = mk(1, 0,  0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0,     0,     0, 0, 0);
        tbl[1]  = mk(0, 0,  1, 0, 0, 1, 0, 3,    0, 0, 0,     0, 0,     0,     0, 0, 3);
        tbl[2]  = mk(0, 1,  1, 0, 0, 0, 1, 0,    1, 0, 'h40,  0, 0,     0,     0, 0, 1);
        tbl[3]  = mk(0, 0,  1, 0, 0, 0, 1, 0,    1, 0, 'h40,  1, 'h100, 'h40,  2, 0, 0);
        tbl[4]  = mk(0, 0,  0, 0, 1, 0, 3, 0,    0, 0, 0,     0, 0,     'h40,  2, 1, 0);
        tbl[5]  = mk(0, 0,  1, 1, 0, 0, 2, 0,    0, 0, 0,     0, 0,     'h40,  2, 0, 'h40);
        tbl[6]  = mk(0, 0,  1, 0, 0, 1, 0, 'h1F, 0, 0, 0,     0, 0,     'h40,  2, 0, 'h1F);
        tbl[7]  = mk(0, 10, 0, 0, 1, 0, 1, 0,    0, 0, 0,     0, 0,     'h40,  2, 0, 'hA);
        tbl[8]  = mk(0, 10, 1, 0, 0, 0, 3, 0,    0, 1, 'h200, 1, 'h110, 'h200, 1, 0, 1);
        tbl[9]  = mk(0, 10, 0, 0, 0, 0, 1, 0,    0, 0, 0,     0, 0,     'h200, 1, 1, 8);
        tbl[10] = mk(0, 0,  1, 1, 0, 0, 1, 0,    1, 1, 'h300, 0, 0,     'h200, 1, 0, 8);
        tbl[11] = mk(0, 0,  1, 0, 0, 0, 3, 0,    1, 1, 'h300, 1, 'h130, 'h300, 3, 0, 3);
        tbl[12] = mk(0, 0,  0, 0, 0, 0, 1, 0,    0, 0, 0,     0, 0,     'h300, 3, 1, 0);
        tbl[13] = mk(1, 0,  0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0,     0,     0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; irq_in = tbl[i].irq; instr_valid = tbl[i].iv;
            is_iret = tbl[i].iret; is_rdcsr = tbl[i].rd; is_wrcsr = tbl[i].wr;
            csr_addr = tbl[i].addr; csr_wdata = tbl[i].wdata;
            gt_flag = tbl[i].gt; eq_flag = tbl[i].eq; pc_next = tbl[i].pc;
            tick();
            chk($sformatf("vec%0d", i), dut_out(),
                pack(tbl[i].take, tbl[i].vec, tbl[i].epc, tbl[i].flags, tbl[i].isr,
                     tbl[i].rdata, tbl[i].rd && tbl[i].rdata != 0));
        end

        // Handler holds off a new request until the cycle after iret retires
        gt_flag = 0; eq_flag = 0; pc_next = 32'h500;
        drv(0, 1, 0, 0, 1, 0, 'h1F); tick();
        drv(1, 1, 0, 0, 0, 1, 0);    tick();
        drv(0, 1, 0, 0, 0, 1, 0);    tick();
        chk32("isr_entry_take", 32'(take_irq), 1);
        drv(4, 1, 0, 0, 0, 1, 0);    tick();
        chk32("isr_in_isr", 32'(in_isr), 1);
        chk32("isr_pend_accum", csr_rdata, 4);
        drv(0, 1, 0, 0, 0, 1, 0);    tick();
        chk32("isr_no_nest0", 32'(take_irq), 0);
        tick();
        chk32("isr_no_nest1", 32'(take_irq), 0);
        drv(0, 1, 1, 0, 0, 1, 0);    tick();
        chk32("iret_state", {30'd0, take_irq, in_isr}, 0);
        drv(0, 1, 0, 0, 0, 1, 0);    tick();
        chk32("reentry_take", 32'(take_irq), 1);
        chk32("reentry_vec", irq_vector, 32'h120);

        // Pending is visible and W1C-clearable while gie is off
        rst = 1'b1; tick();
        drv(0, 1, 0, 0, 1, 0, 'h1E); tick();
        drv(4, 0, 0, 0, 0, 1, 0);    tick();
        drv(0, 1, 0, 1, 0, 1, 0);    #1;
        chk32("rd_pend", csr_rdata, 4);
        chk32("rd_flag1", 32'(csr_flag), 1);
        drv(0, 1, 0, 0, 1, 1, 4);    tick();
        drv(0, 1, 0, 1, 0, 1, 0);    #1;
        chk32("w1c_flag0", {csr_rdata[30:0], csr_flag}, 0);

        // Rise beats a same-cycle clear; iret outside a handler does nothing
        drv(1, 1, 0, 0, 1, 1, 1);    tick();
        chk32("set_wins", csr_rdata, 1);
        drv(0, 1, 1, 0, 0, 2, 0);    tick();
        chk32("iret_in_run", {csr_rdata[29:0], take_irq, in_isr}, 0);

        for (int i = 0; i < 3000; i++) begin
            rst = (i == 0) || ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom);
            instr_valid = ($urandom_range(0, 3) != 0);
            is_iret     = ($urandom_range(0, 5) == 0);
            is_rdcsr    = 1'($urandom);
            is_wrcsr    = ($urandom_range(0, 7) == 0);
            csr_addr    = 2'($urandom);
            csr_wdata   = $urandom;
            gt_flag     = 1'($urandom);
            eq_flag     = 1'($urandom);
            pc_next     = $urandom & 32'hFFFF_FFFC;
            #1;
            if (i > 0) chk($sformatf("rnd%0d", i), dut_out(), model_out());
            model_step();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
